// File: rtl/noc_pkg.sv
// Shared NOC definitions: layer types, PE op modes and default per-layer
// ifmap batch counts used by the sequencer and the NOC datapath.
package noc_pkg;

  typedef enum logic [1:0] {
    NULL   = 2'd0,
    LAYER1 = 2'd1,
    LAYER2 = 2'd2,
    LAYER3 = 2'd3
  } LAYER_TYPE;

  typedef enum logic [1:0] {
    MODE1 = 2'd0,
    MODE2 = 2'd1,
    MODE3 = 2'd2,
    MODE4 = 2'd3
  } OP_MODE;

  localparam int unsigned NOC_L1_BATCHES = 8;
  localparam int unsigned NOC_L2_BATCHES = 4;
  localparam int unsigned NOC_L3_BATCHES = 1;
  localparam int unsigned NOC_CNT_W      = 5;

endpackage

// File: rtl/conv_sequencer.sv
// Layer-level sequencer for the NOC ifmap distribution datapath.
// On an accepted start it configures the NOC for one layer, then for each
// ifmap batch: requests the batch, fires start_conv, waits for the NOC to
// release the buffer, and advances until every batch of the layer is done.
//
// Ports:
//   clk, rst           clock; asynchronous active-high reset
//   start              1-cycle pulse, accepted only when idle
//   layer_type_in      layer to run, sampled on accepted start
//   ifmap_ready        ifmap buffer holds a full batch
//   free_ifmap_buffer  1-cycle pulse from NOC: batch consumed
//   noc_start          1-cycle pulse: clear NOC counters
//   start_conv         1-cycle pulse: NOC/PEs latch batch and mode_out
//   layer_type_out     registered layer type to the NOC
//   mode_out           op mode of the batch in flight
//   ifmap_req          level request for the next batch
//   batch_idx          0-based index of the batch in flight
//   busy               high whenever not idle
//   layer_done         1-cycle pulse: all batches released
module conv_sequencer
  import noc_pkg::*;
#(
  parameter int unsigned L1_BATCHES = NOC_L1_BATCHES,
  parameter int unsigned L2_BATCHES = NOC_L2_BATCHES,
  parameter int unsigned L3_BATCHES = NOC_L3_BATCHES,
  parameter int unsigned CNT_W      = NOC_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  LAYER_TYPE        layer_type_in,
  input  logic             ifmap_ready,
  input  logic             free_ifmap_buffer,
  output logic             noc_start,
  output logic             start_conv,
  output LAYER_TYPE        layer_type_out,
  output OP_MODE           mode_out,
  output logic             ifmap_req,
  output logic [CNT_W-1:0] batch_idx,
  output logic             busy,
  output logic             layer_done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    FETCH = 3'd2,
    CONV  = 3'd3,
    RUN   = 3'd4,
    NEXT  = 3'd5,
    DONE  = 3'd6
  } SEQ_STATE;

  SEQ_STATE         state;
  logic [CNT_W-1:0] last_idx;
  OP_MODE           next_mode;

  // Index of the final batch for a layer; NULL never reaches the batch loop.
  function automatic logic [CNT_W-1:0] last_idx_of(input LAYER_TYPE lt);
    case (lt)
      LAYER1:  return CNT_W'(L1_BATCHES - 1);
      LAYER2:  return CNT_W'(L2_BATCHES - 1);
      LAYER3:  return CNT_W'(L3_BATCHES - 1);
      default: return '0;
    endcase
  endfunction

  // Mode for the batch about to be latched by start_conv.
  always_comb begin
    next_mode = MODE1;
    case (layer_type_out)
      LAYER1:  next_mode = batch_idx[0] ? MODE2 : MODE1;
      LAYER2:  next_mode = MODE3;
      LAYER3:  next_mode = MODE4;
      default: next_mode = MODE1;
    endcase
  end

  // Pulses for INIT and DONE are emitted on the edge leaving those states,
  // giving the 2-cycle start->noc_start and NULL start->layer_done latency.
  // start_conv and mode_out are set on the edge entering CONV so the NOC
  // sees them one cycle after ifmap_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      layer_type_out <= NULL;
      mode_out       <= MODE1;
      noc_start      <= 1'b0;
      start_conv     <= 1'b0;
      ifmap_req      <= 1'b0;
      batch_idx      <= '0;
      busy           <= 1'b0;
      layer_done     <= 1'b0;
      last_idx       <= '0;
    end else begin
      noc_start  <= 1'b0;
      start_conv <= 1'b0;
      layer_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            layer_type_out <= layer_type_in;
            last_idx       <= last_idx_of(layer_type_in);
            batch_idx      <= '0;
            busy           <= 1'b1;
            state          <= (layer_type_in == NULL) ? DONE : INIT;
          end
        end
        INIT: begin
          noc_start <= 1'b1;
          ifmap_req <= 1'b1;
          state     <= FETCH;
        end
        FETCH: begin
          if (ifmap_ready) begin
            ifmap_req  <= 1'b0;
            start_conv <= 1'b1;
            mode_out   <= next_mode;
            state      <= CONV;
          end
        end
        CONV: begin
          state <= RUN;
        end
        RUN: begin
          if (free_ifmap_buffer) state <= NEXT;
        end
        NEXT: begin
          if (batch_idx == last_idx) begin
            state <= DONE;
          end else begin
            batch_idx <= batch_idx + CNT_W'(1);
            ifmap_req <= 1'b1;
            state     <= FETCH;
          end
        end
        DONE: begin
          layer_done <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
